// File: rtl/move_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : move_encoder
//  Purpose  : Debounces the nine cell push-buttons and turns one accepted
//             press into a board position (1..9) with a one-cycle strobe,
//             rejecting multi-button and occupied-cell selections.
//  Revision : 1.0  initial release
// ============================================================================
module move_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] buttons,
    input  logic [8:0] occupied,
    input  logic       enable,
    output logic [3:0] pos,
    output logic       pos_valid,
    output logic       illegal,
    output logic       busy
);

    localparam int                   c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ISSUE    = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    logic [1:0]         r_state;
    logic [8:0]         r_snapshot;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_pos;
    logic               r_pos_valid;
    logic               r_illegal;
    logic               r_busy;

    logic [1:0]         w_state_nxt;
    logic [8:0]         w_snapshot_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [3:0]         w_pos_nxt;
    logic               w_valid_nxt;
    logic               w_illegal_nxt;
    logic               w_onehot;
    logic               w_taken;
    logic [3:0]         w_index;

    // Cell number of the snapshot; only meaningful when it is one-hot,
    // so it can never exceed 9.
    always_comb begin
        w_index = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r_snapshot[i]) begin
                w_index = 4'(i + 1);
            end
        end
    end

    assign w_onehot = (r_snapshot != 9'd0) &&
                      ((r_snapshot & (r_snapshot - 9'd1)) == 9'd0);
    assign w_taken  = (r_snapshot & occupied) != 9'd0;

    always_comb begin
        w_state_nxt    = r_state;
        w_snapshot_nxt = r_snapshot;
        w_count_nxt    = r_count;
        w_pos_nxt      = r_pos;
        w_valid_nxt    = 1'b0;
        w_illegal_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (enable && (buttons != 9'd0)) begin
                    w_snapshot_nxt = buttons;
                    w_count_nxt    = '0;
                    w_state_nxt    = c_DEBOUNCE;
                end
            end
            c_DEBOUNCE: begin
                if (buttons == 9'd0) begin
                    w_state_nxt = c_IDLE;
                end else if (buttons != r_snapshot) begin
                    // Any change restarts the full stability window.
                    w_snapshot_nxt = buttons;
                    w_count_nxt    = '0;
                end else if (!enable) begin
                    w_state_nxt = c_RELEASE;
                end else if (r_count == c_CNT_LAST) begin
                    w_state_nxt = c_ISSUE;
                    if (w_onehot && !w_taken) begin
                        w_pos_nxt   = w_index;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
            end
            c_ISSUE: begin
                w_state_nxt = c_RELEASE;
            end
            c_RELEASE: begin
                if (buttons == 9'd0) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_snapshot  <= 9'd0;
            r_count     <= '0;
            r_pos       <= 4'd0;
            r_pos_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_snapshot  <= w_snapshot_nxt;
            r_count     <= w_count_nxt;
            r_pos       <= w_pos_nxt;
            r_pos_valid <= w_valid_nxt;
            r_illegal   <= w_illegal_nxt;
            r_busy      <= (w_state_nxt != c_IDLE);
        end
    end

    assign pos       = r_pos;
    assign pos_valid = r_pos_valid;
    assign illegal   = r_illegal;
    assign busy      = r_busy;

endmodule
`default_nettype wire
